// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM encoding, quarter phases, R/W codes.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_START  = 4'd1,
      ST_ADDR   = 4'd2,
      ST_ACK_A  = 4'd3,
      ST_WR     = 4'd4,
      ST_ACK_W  = 4'd5,
      ST_RD     = 4'd6,
      ST_NACK_R = 4'd7,
      ST_STOP   = 4'd8
   } i2c_state_e;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_clk_div.sv
// SCL quarter-period timer: down-counter reloads every DIV clks, q steps 0..3.
// Held at reload/q0 while disabled so every transaction starts on a fresh q0.
module i2c_clk_div
   import i2c_pkg::*;
#(
   parameter int DIV   = 250,
   parameter int DIV_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       tick,
   output logic [1:0] q
);

   localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [1:0]       q_q, q_d;

   assign tick = en && (cnt_q == '0);
   assign q    = q_q;

   // Next count and quarter index; terminal count reloads and advances q.
   always_comb begin
      cnt_d = cnt_q;
      q_d   = q_q;
      if (!en) begin
         cnt_d = RELOAD;
         q_d   = Q0;
      end else if (cnt_q == '0) begin
         cnt_d = RELOAD;
         q_d   = q_q + 2'd1;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         q_q   <= Q0;
      end else begin
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C initiator: START, addr+R/W, ACK, one data byte, STOP.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | lines released, waiting for start
//   START     | SDA falls after q1 while SCL high; SCL falls entering ADDR
//   ADDR      | shift {addr,rw} MSB first, 8 bits
//   ACK_A     | SDA released, slave ACK sampled at q2; NACK -> STOP
//   WR        | shift data byte MSB first, 8 bits
//   ACK_W     | SDA released, slave ACK sampled at q2
//   RD        | SDA released, 8 bits sampled at q2 into shift register
//   NACK_R    | SDA released (master NACK); data_rd loaded at the end
//   STOP      | SDA low, SCL released, then SDA released; done follows
module i2c_master
   import i2c_pkg::*;
#(
   parameter int DIV   = 250,
   parameter int DIV_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] data_wr,
   output logic [7:0] data_rd,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   inout  wire        sda,
   inout  wire        scl
);

   i2c_state_e state_q, state_d;
   logic       rw_q, rw_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] data_q, data_d;
   logic [2:0] bit_q, bit_d;
   logic       samp_q, samp_d;
   logic       ack_err_q, ack_err_d;
   logic       done_q, done_d;
   logic [7:0] data_rd_q, data_rd_d;
   logic       sda_low_q, sda_low_d;
   logic       scl_low_q, scl_low_d;
   logic       sda_meta_q, sda_sync_q;
   logic       tick;
   logic [1:0] q;

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign ack_err = ack_err_q;
   assign data_rd = data_rd_q;

   assign sda = sda_low_q ? 1'b0 : 1'bz;
   assign scl = scl_low_q ? 1'b0 : 1'bz;

   i2c_clk_div #(.DIV(DIV), .DIV_W(DIV_W)) u_clk_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy),
      .tick  (tick),
      .q     (q)
   );

   // Two-flop synchroniser on the sampled data line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
      end else begin
         sda_meta_q <= sda;
         sda_sync_q <= sda_meta_q;
      end
   end

   // Next-state, capture, sampling and bit counting; moves happen at the q3 tick.
   always_comb begin
      state_d   = state_q;
      rw_d      = rw_q;
      sh_d      = sh_q;
      data_d    = data_q;
      bit_d     = bit_q;
      samp_d    = samp_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      data_rd_d = data_rd_q;
      if (state_q == ST_IDLE) begin
         // done_q high means this is the cycle right after a transaction: ignore start
         if (start && !done_q) begin
            state_d   = ST_START;
            rw_d      = rw;
            sh_d      = {addr, rw};
            data_d    = data_wr;
            ack_err_d = 1'b0;
         end
      end else if (tick) begin
         if (q == Q2) begin
            samp_d = sda_sync_q;
            if (state_q == ST_RD) sh_d = {sh_q[6:0], sda_sync_q};
         end
         if (q == Q3) begin
            case (state_q)
               ST_START: begin
                  state_d = ST_ADDR;
                  bit_d   = 3'd7;
               end
               ST_ADDR, ST_WR: begin
                  sh_d  = {sh_q[6:0], 1'b0};
                  bit_d = bit_q - 3'd1;
                  if (bit_q == 3'd0) state_d = (state_q == ST_ADDR) ? ST_ACK_A : ST_ACK_W;
               end
               ST_ACK_A: begin
                  if (samp_q) begin
                     ack_err_d = 1'b1;
                     state_d   = ST_STOP;
                  end else if (rw_q == I2C_RW_READ) begin
                     state_d = ST_RD;
                     bit_d   = 3'd7;
                  end else begin
                     state_d = ST_WR;
                     sh_d    = data_q;
                     bit_d   = 3'd7;
                  end
               end
               ST_ACK_W: begin
                  if (samp_q) ack_err_d = 1'b1;
                  state_d = ST_STOP;
               end
               ST_RD: begin
                  bit_d = bit_q - 3'd1;
                  if (bit_q == 3'd0) state_d = ST_NACK_R;
               end
               ST_NACK_R: begin
                  data_rd_d = sh_q;
                  state_d   = ST_STOP;
               end
               ST_STOP: begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   // Line decode per state and quarter; registered so the pads never glitch.
   always_comb begin
      sda_low_d = 1'b0;
      scl_low_d = 1'b0;
      case (state_q)
         ST_START: sda_low_d = (q == Q2) || (q == Q3);
         ST_ADDR, ST_WR: begin
            sda_low_d = ~sh_q[7];
            scl_low_d = (q == Q0) || (q == Q3);
         end
         ST_ACK_A, ST_ACK_W, ST_RD, ST_NACK_R: scl_low_d = (q == Q0) || (q == Q3);
         ST_STOP: begin
            sda_low_d = (q == Q0) || (q == Q1);
            scl_low_d = (q == Q0);
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset releases both lines at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rw_q      <= I2C_RW_WRITE;
         sh_q      <= '0;
         data_q    <= '0;
         bit_q     <= '0;
         samp_q    <= 1'b0;
         ack_err_q <= 1'b0;
         done_q    <= 1'b0;
         data_rd_q <= '0;
         sda_low_q <= 1'b0;
         scl_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rw_q      <= rw_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         bit_q     <= bit_d;
         samp_q    <= samp_d;
         ack_err_q <= ack_err_d;
         done_q    <= done_d;
         data_rd_q <= data_rd_d;
         sda_low_q <= sda_low_d;
         scl_low_q <= scl_low_d;
      end
   end

endmodule
